// File: rtl/vga_sequencer.sv
// Display-list sequencer: fetches two-word commands from a list RAM and replays
// them as Wishbone register writes into the VGA core, with JUMP/HALT flow control.
module vga_sequencer #(
    parameter int unsigned LIST_AW   = 6,
    parameter logic [31:0] CORE_BASE = 32'h0400_0000,
    parameter int unsigned TO_W      = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               error,
    output logic [LIST_AW-1:0] pc_o,
    output logic [15:0]        writes_o,
    output logic [LIST_AW-1:0] list_addr,
    input  logic [31:0]        list_data,
    output logic [31:0]        wbm_addr_o,
    output logic [31:0]        wbm_data_o,
    output logic [3:0]         wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_stb_o,
    output logic               wbm_cyc_o,
    input  logic               wbm_ack_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FH   = 3'd1;
    localparam logic [2:0] S_FHW  = 3'd2;
    localparam logic [2:0] S_FD   = 3'd3;
    localparam logic [2:0] S_FDW  = 3'd4;
    localparam logic [2:0] S_BUS  = 3'd5;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_JUMP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;

    // Watchdog value one below all-ones: the last BUS cycle allowed without ack.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [2:0]         state, state_nxt;
    logic [LIST_AW-1:0] pc_nxt;
    logic [1:0]         hdr_op, hdr_op_nxt;
    logic [7:0]         hdr_off, hdr_off_nxt;
    logic [TO_W-1:0]    wd, wd_nxt;
    logic [15:0]        writes_nxt;
    logic               error_nxt;
    logic [31:0]        addr_nxt, data_nxt;
    logic               bus_nxt;

    assign list_addr = pc_o;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_o;
        hdr_op_nxt  = hdr_op;
        hdr_off_nxt = hdr_off;
        wd_nxt      = wd;
        writes_nxt  = writes_o;
        error_nxt   = error;
        addr_nxt    = wbm_addr_o;
        data_nxt    = wbm_data_o;
        bus_nxt     = 1'b0;

        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt  = S_FH;
                        pc_nxt     = '0;
                        error_nxt  = 1'b0;
                        writes_nxt = '0;
                    end
                end
                S_FH: state_nxt = S_FHW;
                S_FHW: begin
                    hdr_op_nxt  = list_data[31:30];
                    hdr_off_nxt = list_data[7:0];
                    pc_nxt      = pc_o + LIST_AW'(1);
                    state_nxt   = S_FD;
                end
                S_FD: state_nxt = S_FDW;
                S_FDW: begin
                    pc_nxt = pc_o + LIST_AW'(1);
                    case (hdr_op)
                        OP_WRITE: begin
                            state_nxt = S_BUS;
                            addr_nxt  = CORE_BASE | 32'(hdr_off);
                            data_nxt  = list_data;
                            bus_nxt   = 1'b1;
                            wd_nxt    = '0;
                        end
                        OP_JUMP: begin
                            state_nxt = S_FH;
                            pc_nxt    = list_data[LIST_AW-1:0];
                        end
                        OP_HALT: state_nxt = S_IDLE;
                        default: begin
                            state_nxt = S_IDLE;
                            error_nxt = 1'b1;
                        end
                    endcase
                end
                S_BUS: begin
                    if (wbm_ack_i) begin
                        writes_nxt = writes_o + 16'(1);
                        state_nxt  = S_FH;
                    end else if (wd == WD_LAST) begin
                        wd_nxt    = wd + TO_W'(1);
                        error_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        wd_nxt  = wd + TO_W'(1);
                        bus_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_o       <= '0;
            hdr_op     <= '0;
            hdr_off    <= '0;
            wd         <= '0;
            writes_o   <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
            wbm_addr_o <= '0;
            wbm_data_o <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cyc_o  <= 1'b0;
        end else begin
            pc_o       <= pc_nxt;
            hdr_op     <= hdr_op_nxt;
            hdr_off    <= hdr_off_nxt;
            wd         <= wd_nxt;
            writes_o   <= writes_nxt;
            error      <= error_nxt;
            busy       <= (state_nxt != S_IDLE);
            wbm_addr_o <= addr_nxt;
            wbm_data_o <= data_nxt;
            wbm_sel_o  <= bus_nxt ? 4'hF : 4'h0;
            wbm_we_o   <= bus_nxt;
            wbm_stb_o  <= bus_nxt;
            wbm_cyc_o  <= bus_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sequencer.sv
// Bench for vga_sequencer: list RAM and Wishbone slave models, expected writes
// queued per scenario and popped as the slave acknowledges them.
module tb_vga_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, stop;
    logic        busy, error;
    logic [5:0]  pc_o, list_addr;
    logic [15:0] writes_o;
    logic [31:0] list_data;
    logic [31:0] wbm_addr_o, wbm_data_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

    // Second instance with a 4-bit watchdog and a slave that never acks.
    logic        start_w, stop_w;
    logic        busy_w, error_w;
    logic [5:0]  pc_w, list_addr_w;
    logic [15:0] writes_w;
    logic [31:0] list_data_w;
    logic [31:0] addr_w, data_w;
    logic [3:0]  sel_w;
    logic        we_w, stb_w, cyc_w;
    logic        ack_w = 1'b0;

    logic [31:0] mem   [64];
    logic [31:0] mem_w [64];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int hold   = 0;
    int slv_cnt;

    always #5 clk = ~clk;

    vga_sequencer #(.LIST_AW(6), .CORE_BASE(32'h0400_0000), .TO_W(20)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .busy(busy), .error(error), .pc_o(pc_o), .writes_o(writes_o),
        .list_addr(list_addr), .list_data(list_data),
        .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i)
    );

    vga_sequencer #(.LIST_AW(6), .CORE_BASE(32'h0400_0000), .TO_W(4)) dut_wd (
        .clk(clk), .reset_n(reset_n), .start(start_w), .stop(stop_w),
        .busy(busy_w), .error(error_w), .pc_o(pc_w), .writes_o(writes_w),
        .list_addr(list_addr_w), .list_data(list_data_w),
        .wbm_addr_o(addr_w), .wbm_data_o(data_w), .wbm_sel_o(sel_w),
        .wbm_we_o(we_w), .wbm_stb_o(stb_w), .wbm_cyc_o(cyc_w),
        .wbm_ack_i(ack_w)
    );

    always @(posedge clk) begin
        list_data   <= mem[list_addr];
        list_data_w <= mem_w[list_addr_w];
    end

    // Registered slave: acks after stb has been seen for hold+1 edges.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbm_ack_i <= 1'b0;
            slv_cnt   <= 0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            if (slv_cnt >= hold) wbm_ack_i <= 1'b1;
            else slv_cnt <= slv_cnt + 1;
        end else begin
            wbm_ack_i <= 1'b0;
            slv_cnt   <= 0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i]   = 32'h8000_0000;
            mem_w[i] = 32'h8000_0000;
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic stop_pulse();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    // Pops one expected write per acknowledged transfer; ends one cycle past the last ack.
    task automatic wait_acks(input int n, input int budget);
        int got = 0;
        int t = 0;
        wr_t e;
        while (got < n && t < budget) begin
            if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required none", wbm_addr_o, wbm_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (wbm_addr_o !== e.addr || wbm_data_o !== e.data ||
                        wbm_sel_o !== 4'hF || wbm_we_o !== 1'b1) begin
                        errors++;
                        $display("FAIL write: got addr %h data %h sel %h we %b, required addr %h data %h sel f we 1",
                                 wbm_addr_o, wbm_data_o, wbm_sel_o, wbm_we_o, e.addr, e.data);
                    end
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL ack_timeout: got %0d acks, required %0d", got, n);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; start_w = 1'b0; stop_w = 1'b0;
        clear_mem();
        #1;
        checks++;
        if ({busy, error, pc_o, writes_o, list_addr, wbm_addr_o, wbm_data_o, wbm_sel_o,
             wbm_we_o, wbm_stb_o, wbm_cyc_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy %b error %b pc %h writes %h stb %b, required all 0",
                     busy, error, pc_o, writes_o, wbm_stb_o);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wbm_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy %b stb %b, required 0 0", busy, wbm_stb_o);
        end
    endtask

    task automatic test_single_write();
        int n;
        clear_mem();
        mem[0] = 32'h0000_0008; mem[1] = 32'h0070_0000; mem[2] = 32'h8000_0000;
        hold = 0;
        push_wr(32'h0400_0008, 32'h0070_0000);
        start_pulse();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b in cycle 1, required 1", busy);
        end
        n = 1;
        while (wbm_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL stb_cycle: stb rose in cycle %0d, required 5", n);
        end
        wait_acks(1, 20);
        wait_idle(20, n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL halt_latency: idle %0d cycles after ack+1, required 4", n);
        end
        checks++;
        if (writes_o !== 16'd1 || error !== 1'b0 || pc_o !== 6'd4) begin
            errors++;
            $display("FAIL single_end: got writes %0d error %b pc %0d, required 1 0 4", writes_o, error, pc_o);
        end
    endtask

    task automatic test_blocking_wait();
        int n;
        logic [31:0] a0, d0;
        logic stable;
        clear_mem();
        mem[0] = 32'h0000_0018; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'h8000_0000;
        hold = 1000;
        push_wr(32'h0400_0018, 32'hDEAD_BEEF);
        start_pulse();
        n = 0;
        while (wbm_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        a0 = wbm_addr_o; d0 = wbm_data_o;
        stable = 1'b1;
        n = 0;
        while (wbm_stb_o === 1'b1 && wbm_ack_i !== 1'b1 && n < 1100) begin
            if (wbm_addr_o !== a0 || wbm_data_o !== d0 || wbm_cyc_o !== 1'b1) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!stable || a0 !== 32'h0400_0018 || d0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wait_stable: addr %h data %h stable %b, required 04000018 deadbeef 1", a0, d0, stable);
        end
        checks++;
        if (n != hold + 1) begin
            errors++;
            $display("FAIL wait_length: stb held %0d cycles without ack, required %0d", n, hold + 1);
        end
        wait_acks(1, 5);
        checks++;
        if (wbm_stb_o !== 1'b0 || list_addr !== 6'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL next_fetch: got stb %b list_addr %0d busy %b, required 0 2 1", wbm_stb_o, list_addr, busy);
        end
        wait_idle(20, n);
        hold = 0;
    endtask

    task automatic test_loop_stop();
        int n;
        clear_mem();
        mem[0] = 32'h0000_0004; mem[1] = 32'h0000_1234;
        mem[2] = 32'h0000_0008; mem[3] = 32'h0000_5678;
        mem[4] = 32'h4000_0000; mem[5] = 32'h0000_0000;
        hold = 0;
        for (int i = 0; i < 2; i++) begin
            push_wr(32'h0400_0004, 32'h0000_1234);
            push_wr(32'h0400_0008, 32'h0000_5678);
        end
        start_pulse();
        wait_acks(2, 40);
        repeat (4) @(negedge clk);
        checks++;
        if (list_addr !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL jump_target: got list_addr %0d busy %b, required 0 1", list_addr, busy);
        end
        wait_acks(2, 40);
        n = 0;
        while (wbm_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        stop_pulse();
        checks++;
        if (wbm_stb_o !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_bus: got stb %b cyc %b busy %b, required 0 0 0", wbm_stb_o, wbm_cyc_o, busy);
        end
        checks++;
        if (writes_o !== 16'd4 || error !== 1'b0) begin
            errors++;
            $display("FAIL stop_counts: got writes %0d error %b, required 4 0", writes_o, error);
        end
    endtask

    task automatic test_wrap();
        int n;
        clear_mem();
        mem[0] = 32'h4000_0000; mem[1] = 32'h0000_003F;
        mem[2] = 32'h8000_0000; mem[3] = 32'h8000_0000;
        mem[63] = 32'h0000_0024;
        push_wr(32'h0400_0024, 32'h4000_0000);
        push_wr(32'h0400_003F, 32'h8000_0000);
        start_pulse();
        checks++;
        if (writes_o !== 16'd0) begin
            errors++;
            $display("FAIL writes_clear: got %0d after start, required 0", writes_o);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (list_addr !== 6'd63) begin
            errors++;
            $display("FAIL jump_63: got list_addr %0d, required 63", list_addr);
        end
        wait_acks(2, 40);
        wait_idle(20, n);
        checks++;
        if (pc_o !== 6'd5 || writes_o !== 16'd2 || error !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: got pc %0d writes %0d error %b, required 5 2 0", pc_o, writes_o, error);
        end
    endtask

    task automatic test_reserved();
        clear_mem();
        mem[0] = 32'hC000_0000; mem[1] = 32'h0000_0000;
        start_pulse();
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reserved_early: got error %b busy %b in cycle 4, required 0 1", error, busy);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: got error %b busy %b in cycle 5, required 1 0", error, busy);
        end
    endtask

    task automatic test_collisions();
        int n;
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL start_stop: got busy %b error %b, required 0 1", busy, error);
        end
        clear_mem();
        mem[0] = 32'h0000_0004; mem[1] = 32'h0000_1234;
        mem[2] = 32'h4000_0000; mem[3] = 32'h0000_0000;
        hold = 0;
        push_wr(32'h0400_0004, 32'h0000_1234);
        start_pulse();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got %b after start, required 0", error);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (pc_o !== 6'd1) begin
            errors++;
            $display("FAIL start_busy_pc: got pc %0d in cycle 3, required 1", pc_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wbm_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_stb: got stb %b in cycle 5, required 1", wbm_stb_o);
        end
        wait_acks(1, 10);
        stop_pulse();
        wait_idle(5, n);
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mem();
        mem[0] = 32'h0000_0018; mem[1] = 32'h1234_5678;
        hold = 1000;
        start_pulse();
        n = 0;
        while (wbm_stb_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, error, pc_o, writes_o, list_addr, wbm_addr_o, wbm_data_o, wbm_sel_o,
             wbm_we_o, wbm_stb_o, wbm_cyc_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy %b stb %b cyc %b addr %h pc %0d, required all 0",
                     busy, wbm_stb_o, wbm_cyc_o, wbm_addr_o, pc_o);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wbm_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got busy %b stb %b, required 0 0", busy, wbm_stb_o);
        end
        hold = 0;
        mem[0] = 32'h8000_0000;
        start_pulse();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset: got busy %b, required 1", busy);
        end
        wait_idle(20, n);
    endtask

    task automatic test_watchdog();
        int n;
        mem_w[0] = 32'h0000_0018; mem_w[1] = 32'h0000_0055;
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        n = 0;
        while (stb_w !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (stb_w === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL wd_length: stb high %0d cycles, required 15", n);
        end
        checks++;
        if (error_w !== 1'b1 || busy_w !== 1'b0 || cyc_w !== 1'b0) begin
            errors++;
            $display("FAIL wd_abort: got error %b busy %b cyc %b, required 1 0 0", error_w, busy_w, cyc_w);
        end
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        checks++;
        if (error_w !== 1'b0 || busy_w !== 1'b1) begin
            errors++;
            $display("FAIL wd_restart: got error %b busy %b, required 0 1", error_w, busy_w);
        end
        @(negedge clk) stop_w = 1'b1;
        @(negedge clk) stop_w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_blocking_wait();
        test_loop_stop();
        test_wrap();
        test_reserved();
        test_collisions();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sequencer.md
# vga_sequencer

Display-list sequencer that drives the Wishbone slave port of the VGA core as a bus master. It fetches command pairs from a synchronous list memory and issues register writes, including blocking wait-for-condition writes to offset 0x18, so mode setup and mid-frame background changes run without CPU involvement. `JUMP` commands let a list loop once per frame. The block sits between the list RAM and the VGA core register port.

## Interface
- `LIST_AW`, 6: list memory address width; 2^LIST_AW words.
- `CORE_BASE`, 32'h0400_0000: base address ORed with the 8-bit register offset.
- `TO_W`, 20: width of the bus watchdog counter.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins execution at list word 0.
- `stop` in 1: one-cycle pulse; aborts execution.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky; cleared by an accepted `start`.
- `pc_o` out LIST_AW: current list pointer.
- `writes_o` out 16: count of acked writes since the last accepted `start`; wraps.
- `list_addr` out LIST_AW: list read address, equal to `pc`.
- `list_data` in 32: list read data, valid one cycle after `list_addr`.
- `wbm_addr_o` out 32, `wbm_data_o` out 32, `wbm_sel_o` out 4, `wbm_we_o` out 1, `wbm_stb_o` out 1, `wbm_cyc_o` out 1: Wishbone master signals.
- `wbm_ack_i` in 1: slave acknowledge.

## Operation
- Each command is two words: a header at `pc`, then data at `pc+1`.
  - Header bits [31:30] are the opcode: 00 WRITE, 01 JUMP, 10 HALT, 11 reserved.
  - Header bits [7:0] are the register offset. All other header bits are ignored.
- States and transitions:
  - IDLE → FH on an accepted `start`; `pc`←0.
  - FH → FHW.
  - FHW: capture header; `pc`←`pc`+1; go to FD.
  - FD → FDW.
  - FDW: capture data; `pc`←`pc`+1; then decode:
    - WRITE → BUS.
    - JUMP → FH with `pc`←data[LIST_AW-1:0].
    - HALT → IDLE.
    - reserved → IDLE and set `error`.
  - BUS: `cyc`=`stb`=`we`=1, `sel`=4'hF, `addr`=CORE_BASE | offset, `data`=data word. On `ack`: `writes_o`+1 and go to FH.
- The BUS state may last a full frame, because a write to 0x18 is acked only when the condition is met.
- Watchdog:
  - The counter clears on entry to BUS and increments each BUS cycle without `ack`.
  - When it reaches all-ones: drop the bus, set `error`, go to IDLE.
- Arithmetic:
  - `pc` wraps modulo 2^LIST_AW. A header at the last word takes its data from word 0.
  - `writes_o` wraps at 16 bits.
- Start and stop rules:
  - `stop` in any state: IDLE on the next edge; `cyc`/`stb`/`we` are low that cycle; `error` is unchanged.
  - `start` while busy is ignored.
  - `start` and `stop` in the same cycle: `stop` wins; the block remains or returns to IDLE.
- Reset (`reset_n` low, asynchronous): state IDLE; `pc`, `writes_o` and watchdog cleared; all outputs 0, including `wbm_*_o`, `busy`, `error`, `pc_o` and `list_addr`.

## Timing
- All outputs are registered, except `list_addr` = `pc`.
- With `start` sampled at edge 0:
  - FH in cycle 1, FHW in 2, FD in 3, FDW in 4.
  - `stb` first high in cycle 5.
- Each command costs 4 fetch cycles plus the BUS cycles.
- `stb` deasserts on the edge following the sampled `ack`. At least 4 cycles pass with `stb` low before the next transaction, so a registered slave ack always clears in between.
- `busy` rises in cycle 1 after `start` and falls in the cycle IDLE is entered.
- `error` rises in the same cycle IDLE is entered.
- `wbm_data_o` and `wbm_addr_o` are stable for the whole BUS state.

## Test plan
- **Single write:**
  - List: [0]=0x0000_0008, [1]=0x0070_0000, [2]=HALT 0x8000_0000.
  - Slave acks one cycle after `stb`.
  - Required: a write to 0x0400_0008 with data 0x0070_0000; `stb` rises in cycle 5; `writes_o`=1; IDLE after the HALT fetch; `error`=0.
- **Blocking wait:**
  - Write to 0x18, with the slave holding `ack` low for 1000 cycles.
  - Required: `stb`, `addr` and `data` are constant for 1000 cycles; the next header fetch occurs 1 cycle after `ack`.
- **Loop and wrap:**
  - JUMP with data 0 at words 4–5, and a WRITE at words 63/0 with LIST_AW=6.
  - Required: the JUMP returns `pc` to 0; the data for the word-63 header is taken from word 0.
- **Watchdog:**
  - TO_W=4 and `ack` never asserted.
  - Required: `stb` drops after 15 BUS cycles; `error`=1; `busy`=0; a later `start` clears `error`.
- **Stop and start collisions:**
  - `stop` during BUS: `cyc`/`stb` are low on the next edge.
  - `start`+`stop` together from IDLE: the block stays in IDLE.
  - `start` while busy: no restart; `pc` continues.
- **Reset mid-operation:** assert `reset_n` low in BUS. Required: all outputs are 0 immediately (asynchronously), and the block stays in IDLE after release until `start`.
